game_flow_ctrl: RTL
===================

Name: game_flow_ctrl

Overview:
Top-level game sequencer in the VGA clock domain. Owns the menu/play/game-over/score-submit state machine and the menu fade counter. Generates the game-active strobe and reset for the game datapath. Hands the final score to the processor over a four-phase valid/ACK handshake on the shared score bus. The pixel/RGB mux in the VGA controller consumes screen_sel and fade_level.

Parameters:
FADE_MAX, 32'h07FF_FFFF, saturation value of the menu fade counter
FADE_SHIFT, 19, right shift applied to the fade counter to form fade_level
GAMEOVER_HOLD, 25_000_000, cycles the game-over screen is held (about 1 s at 25 MHz)
ACK_TIMEOUT, 1_000_000, cycles to wait for each ACK edge before abandoning a submit

Ports:
iVGA_CLK  in  1  sole clock, VGA pixel clock
iRST_n  in  1  asynchronous active-low reset
up  in  1  ship control, level
down  in  1  ship control, level
left  in  1  ship control, level
right  in  1  ship control, level
fire  in  1  fire button, level
menu  in  1  menu/abort button, level
ship_dead  in  1  game datapath reports HP reached 0, level
score  in  32  live score from the game datapath
ACK  in  32  processor acknowledge word; only bit 0 is used
game_active  out  1  high only in PLAY; drives GAME_MODULE start
game_reset  out  1  one-cycle pulse on entry to PLAY
screen_sel  out  2  0=MENU, 1=PLAY, 2=GAMEOVER, 3=SUBMIT
fade_level  out  8  menu gradient intensity
NEW_SCORE  out  32  score presented to the processor
NEW_SCORE_EN  out  1  valid for NEW_SCORE
submit_err  out  1  sticky flag: a submit timed out (only with the optional feature)

Behaviour:
- Reset (asynchronous, iRST_n low): state=MENU, fade counter=0, NEW_SCORE=0, NEW_SCORE_EN=0, game_active=0, game_reset=0, screen_sel=0, submit_err=0, hold counter=0.
- All outputs are registered. Every transition takes effect on the next iVGA_CLK rising edge.
- MENU:
  - Fade counter increments by 1 per cycle and saturates at FADE_MAX.
  - fade_level = (counter >> FADE_SHIFT)[7:0].
  - Go to PLAY when (up|down|left|right) && !menu. Pulse game_reset for that cycle.
  - Fade counter is not cleared on leaving MENU.
- PLAY:
  - game_active=1 and fade_level=0.
  - menu || ship_dead -> GAMEOVER. Capture score into the internal final_score register on that edge.
  - If both are asserted in the same cycle, a single transition occurs.
- GAMEOVER:
  - Hold counter counts 0..GAMEOVER_HOLD-1 while all inputs are ignored.
  - On reaching GAMEOVER_HOLD-1, go to SUBMIT, drive NEW_SCORE=final_score and NEW_SCORE_EN=1.
- SUBMIT (four-phase handshake):
  - Phase A: NEW_SCORE_EN=1 and NEW_SCORE stable until ACK[0]==1 is sampled.
  - Phase B: NEW_SCORE_EN=0 and NEW_SCORE keeps its value. Wait for ACK[0]==0.
  - Then go to MENU, clear the fade counter to 0, and drive NEW_SCORE=0.
  - If ACK[0] is already 1 on SUBMIT entry, phase A completes on the first SUBMIT cycle.
  - Control inputs are ignored throughout SUBMIT.
- Invariants:
  - NEW_SCORE_EN is never high outside SUBMIT phase A.
  - NEW_SCORE never changes while NEW_SCORE_EN=1.
  - A final score of 0 is still submitted.
- Reset mid-handshake: NEW_SCORE_EN drops asynchronously and the submitted score is lost; no retry after reset.
- Width: score is unsigned 32-bit and captured unchanged, with no clamping.

Optional Feature:
Macro ACK_TIMEOUT_EN.
- Defined:
  - A timeout counter restarts on entry to each handshake phase.
  - Reaching ACK_TIMEOUT cycles in either phase forces NEW_SCORE_EN=0 and state=MENU (fade counter cleared), and sets submit_err=1.
  - submit_err stays set until reset or the next successful phase B completion.
- Undefined: no timeout counter is built, submit_err is tied to 0, and SUBMIT waits indefinitely.

Test Plan:
1. Release reset, idle 2^20 cycles in MENU with FADE_SHIFT=19 -> fade_level=2. Hold idle with FADE_MAX=32'h0000_FFFF -> counter stops at FADE_MAX; fade_level is unaffected by wrap.
2. In MENU pulse right=1 with menu=0 -> next cycle game_active=1, screen_sel=1, game_reset high exactly 1 cycle. Also press up with menu=1 -> stays in MENU.
3. In PLAY with score=32'd1234, assert ship_dead and menu in the same cycle -> single GAMEOVER entry; with GAMEOVER_HOLD=8, NEW_SCORE_EN rises 8 cycles later with NEW_SCORE=1234.
4. Handshake: hold ACK[0]=0 for 50 cycles -> NEW_SCORE_EN stays 1 and NEW_SCORE stays stable. Raise ACK[0] -> EN=0 next cycle. Drop ACK[0] -> screen_sel=0, NEW_SCORE=0.
5. Assert iRST_n=0 asynchronously mid-SUBMIT (between clock edges) -> NEW_SCORE_EN=0 immediately, state=MENU, and no submit after reset release.
6. With ACK_TIMEOUT_EN and ACK_TIMEOUT=16, never raise ACK -> after 16 cycles EN=0, submit_err=1, state=MENU. A later successful submit clears submit_err.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game sequencer: MENU -> PLAY -> GAMEOVER -> SUBMIT (four-phase score handshake) -> MENU.
// Optional macro ACK_TIMEOUT_EN adds a per-phase ACK timeout and the sticky submit_err flag.
module game_flow_ctrl #(
  parameter logic [31:0] FADE_MAX      = 32'h07FF_FFFF,
  parameter int unsigned FADE_SHIFT    = 19,
  parameter logic [31:0] GAMEOVER_HOLD = 32'd25_000_000,
  parameter logic [31:0] ACK_TIMEOUT   = 32'd1_000_000
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        fire,
  input  logic        menu,
  input  logic        ship_dead,
  input  logic [31:0] score,
  input  logic [31:0] ACK,
  output logic        game_active,
  output logic        game_reset,
  output logic [1:0]  screen_sel,
  output logic [7:0]  fade_level,
  output logic [31:0] NEW_SCORE,
  output logic        NEW_SCORE_EN,
  output logic        submit_err
);

  typedef enum logic [2:0] {
    MENU     = 3'd0,
    PLAY     = 3'd1,
    GAMEOVER = 3'd2,
    SUB_A    = 3'd3,
    SUB_B    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fade_q, fade_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] final_q, final_d;
  logic [31:0] new_score_q, new_score_d;
  logic        game_active_q, game_active_d;
  logic        game_reset_q, game_reset_d;
  logic [1:0]  screen_sel_q, screen_sel_d;
  logic [7:0]  fade_level_q, fade_level_d;
  logic        en_q, en_d;
  logic        ack_seen, ack_timeout;

  assign ack_seen = ACK[0];

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q       <= MENU;
      fade_q        <= '0;
      hold_q        <= '0;
      final_q       <= '0;
      new_score_q   <= '0;
      game_active_q <= 1'b0;
      game_reset_q  <= 1'b0;
      screen_sel_q  <= 2'd0;
      fade_level_q  <= 8'd0;
      en_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      fade_q        <= fade_d;
      hold_q        <= hold_d;
      final_q       <= final_d;
      new_score_q   <= new_score_d;
      game_active_q <= game_active_d;
      game_reset_q  <= game_reset_d;
      screen_sel_q  <= screen_sel_d;
      fade_level_q  <= fade_level_d;
      en_q          <= en_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fade_d       = fade_q;
    hold_d       = hold_q;
    final_d      = final_q;
    new_score_d  = new_score_q;
    game_reset_d = 1'b0;
    case (state_q)
      MENU: begin
        fade_d = (fade_q >= FADE_MAX) ? FADE_MAX : fade_q + 32'd1;
        if ((up || down || left || right) && !menu) begin
          state_d      = PLAY;
          game_reset_d = 1'b1;
        end
      end
      PLAY: begin
        if (menu || ship_dead) begin
          state_d = GAMEOVER;
          final_d = score;
          hold_d  = '0;
        end
      end
      GAMEOVER: begin
        if (hold_q == GAMEOVER_HOLD - 32'd1) begin
          state_d     = SUB_A;
          hold_d      = '0;
          new_score_d = final_q;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      SUB_A: begin
        if (ack_seen) begin
          state_d = SUB_B;
        end else if (ack_timeout) begin
          state_d     = MENU;
          fade_d      = '0;
          new_score_d = '0;
        end
      end
      SUB_B: begin
        // Returning to MENU on either completion or timeout restarts the fade from dark.
        if (!ack_seen || ack_timeout) begin
          state_d     = MENU;
          fade_d      = '0;
          new_score_d = '0;
        end
      end
      default: state_d = MENU;
    endcase

    game_active_d = (state_d == PLAY);
    en_d          = (state_d == SUB_A);
    fade_level_d  = (state_d == MENU) ? 8'(fade_d >> FADE_SHIFT) : 8'd0;
    case (state_d)
      MENU:     screen_sel_d = 2'd0;
      PLAY:     screen_sel_d = 2'd1;
      GAMEOVER: screen_sel_d = 2'd2;
      default:  screen_sel_d = 2'd3;
    endcase
  end

`ifdef ACK_TIMEOUT_EN
  logic [31:0] tcnt_q, tcnt_d;
  logic        err_q, err_d;
  logic        in_submit;

  assign in_submit   = (state_q == SUB_A) || (state_q == SUB_B);
  assign ack_timeout = (tcnt_q == ACK_TIMEOUT - 32'd1);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    tcnt_d = tcnt_q + 32'd1;
    err_d  = err_q;
    if (!in_submit || state_d != state_q) tcnt_d = '0;
    if ((state_q == SUB_A && !ack_seen && ack_timeout) ||
        (state_q == SUB_B && ack_seen && ack_timeout))
      err_d = 1'b1;
    if (state_q == SUB_B && !ack_seen) err_d = 1'b0;
  end

  assign submit_err = err_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, ACK[31:1], fire};
`else
  assign ack_timeout = 1'b0;
  assign submit_err  = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, ACK[31:1], fire, ACK_TIMEOUT};
`endif

  assign game_active  = game_active_q;
  assign game_reset   = game_reset_q;
  assign screen_sel   = screen_sel_q;
  assign fade_level   = fade_level_q;
  assign NEW_SCORE    = new_score_q;
  assign NEW_SCORE_EN = en_q;

endmodule
